// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative RV64M multiply/divide unit.
package mdu_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 7;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    typedef enum logic [3:0] {
        MDU_MUL,
        MDU_DIV,
        MDU_DIVU,
        MDU_REM,
        MDU_REMU,
        MDU_MULW,
        MDU_DIVW,
        MDU_DIVUW,
        MDU_REMW,
        MDU_REMUW
    } mdufunc_t;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_BUSY,
        MDU_DONE
    } mdu_state_t;

    function automatic u64 sext32(input u32 v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic u64 zext32(input u32 v);
        return {32'b0, v};
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider datapath: one quotient bit per enabled step on unsigned operands.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic step,
    input  u64   dividend,
    input  u64   divisor,
    output u64   quot,
    output u64   rem
);

    u64          div_q;
    logic [64:0] rem_sh;
    logic [64:0] diff;

    // Bit 64 of the trial difference is the borrow: set means the divisor did not fit.
    always_comb begin
        rem_sh = {rem, quot[63]};
        diff   = rem_sh - {1'b0, div_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quot  <= '0;
            rem   <= '0;
            div_q <= '0;
        end else if (load) begin
            quot  <= dividend;
            rem   <= '0;
            div_q <= divisor;
        end else if (step) begin
            if (!diff[64]) begin
                rem  <= diff[63:0];
                quot <= {quot[62:0], 1'b1};
            end else begin
                rem  <= rem_sh[63:0];
                quot <= {quot[62:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu.sv
// Iterative RV64M multiply/divide unit: fixed 65-cycle latency, valid/ready handshake on both sides.
module mdu
    import mdu_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  logic     in_valid,
    output logic     in_ready,
    input  u64       a,
    input  u64       b,
    input  mdufunc_t func,
    output logic     out_valid,
    input  logic     out_ready,
    output u64       c
);

    mdu_state_t       state;
    logic [CNT_W-1:0] cnt;

    mdufunc_t func_q;
    logic     w_q;
    logic     neg_q;
    logic     neg_r;
    logic     zero_q;
    logic     ovf_q;
    u64       a_q;

    u64 mul_acc;
    u64 mul_cand;
    u64 mul_plier;

    logic op_signed;
    logic op_w;
    u64   a_x;
    u64   b_x;
    logic sign_a;
    logic sign_b;
    u64   abs_a;
    u64   abs_b;
    u64   min_val;
    logic div_zero;
    logic div_ovf;

    u64   quot;
    u64   rem;
    u64   q_fix;
    u64   r_fix;
    u64   res;

    logic div_load;
    logic div_step;

    // Operand conditioning at accept: W forms extend the low word, signed forms divide magnitudes.
    always_comb begin
        op_signed = 1'b0;
        op_w      = 1'b0;
        a_x       = a;
        b_x       = b;
        case (func)
            MDU_DIV, MDU_REM: begin
                op_signed = 1'b1;
            end
            MDU_DIVW, MDU_REMW: begin
                op_signed = 1'b1;
                op_w      = 1'b1;
                a_x       = sext32(a[31:0]);
                b_x       = sext32(b[31:0]);
            end
            MDU_DIVUW, MDU_REMUW: begin
                op_w = 1'b1;
                a_x  = zext32(a[31:0]);
                b_x  = zext32(b[31:0]);
            end
            MDU_MULW: begin
                op_w = 1'b1;
            end
            default: begin
            end
        endcase
        sign_a   = op_signed & a_x[63];
        sign_b   = op_signed & b_x[63];
        abs_a    = sign_a ? -a_x : a_x;
        abs_b    = sign_b ? -b_x : b_x;
        min_val  = op_w ? sext32(32'h8000_0000) : {1'b1, 63'b0};
        div_zero = (b_x == '0);
        div_ovf  = op_signed && (a_x == min_val) && (b_x == '1);
    end

    assign div_load = (state == MDU_IDLE) && in_valid && !flush;
    assign div_step = (state == MDU_BUSY) && (cnt != '0) && !flush;

    mdu_div_core u_div_core (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend (abs_a),
        .divisor  (abs_b),
        .quot     (quot),
        .rem      (rem)
    );

    // Sign fix and RISC-V special cases, applied to the finished magnitudes.
    always_comb begin
        q_fix = neg_q ? -quot : quot;
        r_fix = neg_r ? -rem : rem;
        if (zero_q) begin
            q_fix = '1;
            r_fix = a_q;
        end else if (ovf_q) begin
            q_fix = a_q;
            r_fix = '0;
        end
        case (func_q)
            MDU_DIV, MDU_DIVU, MDU_DIVW, MDU_DIVUW: res = q_fix;
            MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW: res = r_fix;
            default:                                res = mul_acc;
        endcase
        if (w_q) begin
            res = sext32(res[31:0]);
        end
    end

    // The cnt==0 BUSY cycle only registers the fixed result, giving the 65-cycle latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= MDU_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            c         <= '0;
            func_q    <= MDU_MUL;
            w_q       <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            a_q       <= '0;
            mul_acc   <= '0;
            mul_cand  <= '0;
            mul_plier <= '0;
        end else if (flush) begin
            state     <= MDU_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (in_valid) begin
                        state     <= MDU_BUSY;
                        cnt       <= CNT_W'(XLEN);
                        in_ready  <= 1'b0;
                        func_q    <= func;
                        w_q       <= op_w;
                        neg_q     <= sign_a ^ sign_b;
                        neg_r     <= sign_a;
                        zero_q    <= div_zero;
                        ovf_q     <= div_ovf;
                        a_q       <= a_x;
                        mul_acc   <= '0;
                        mul_cand  <= a;
                        mul_plier <= b;
                    end
                end
                MDU_BUSY: begin
                    if (cnt != '0) begin
                        if (mul_plier[0]) begin
                            mul_acc <= mul_acc + mul_cand;
                        end
                        mul_cand  <= mul_cand << 1;
                        mul_plier <= mul_plier >> 1;
                        cnt       <= cnt - CNT_W'(1);
                    end else begin
                        c         <= res;
                        state     <= MDU_DONE;
                        out_valid <= 1'b1;
                    end
                end
                MDU_DONE: begin
                    if (out_ready) begin
                        state     <= MDU_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= MDU_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: directed vectors queued at issue, checked by a monitor on the result handshake.
module tb_mdu;
    import mdu_pkg::*;

    logic     clk       = 1'b0;
    logic     reset     = 1'b0;
    logic     flush     = 1'b0;
    logic     in_valid  = 1'b0;
    logic     in_ready;
    u64       a         = '0;
    u64       b         = '0;
    mdufunc_t func      = MDU_MUL;
    logic     out_valid;
    logic     out_ready = 1'b1;
    u64       c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        u64    c;
        string name;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    mdu dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    task automatic check_output(input string name, input u64 actual, input u64 expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
        end
    endtask

    // Monitor: a result is consumed on the edge following a negedge where valid and ready are both high.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got c=0x%016h, expected no result", c);
            end else begin
                e = sb_q.pop_front();
                check_output(e.name, c, e.c);
            end
        end
    end

    task automatic apply_stimulus(input mdufunc_t f, input u64 av, input u64 bv,
                                  input bit push, input u64 expv, input string name);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check_output({name, "_ready_timeout"}, u64'(in_ready), 64'd1);
            return;
        end
        if (push) sb_q.push_back('{expv, name});
        func     = f;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output({name, "_latency"}, u64'(n), 64'd65);
    endtask

    task automatic run_op(input mdufunc_t f, input u64 av, input u64 bv, input u64 expv, input string name);
        apply_stimulus(f, av, bv, 1'b1, expv, name);
        wait_result(name);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int rises;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_in_ready", u64'(in_ready), 64'd1);
        check_output("reset_out_valid", u64'(out_valid), 64'd0);
        check_output("reset_c", c, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op(MDU_MUL,   64'd7,   -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, "mul_7_m3");
        run_op(MDU_DIV,   -64'sd7, 64'd2,   64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
        run_op(MDU_REM,   -64'sd7, 64'd2,   64'hFFFF_FFFF_FFFF_FFFF, "rem_m7_2");
        run_op(MDU_DIVU,  64'd100, 64'd7,   64'd14,                  "divu_100_7");
        run_op(MDU_REMU,  64'd100, 64'd7,   64'd2,                   "remu_100_7");
        run_op(MDU_DIV,   64'd5,   64'd0,   64'hFFFF_FFFF_FFFF_FFFF, "div_5_0");
        run_op(MDU_REM,   64'd5,   64'd0,   64'd5,                   "rem_5_0");
        run_op(MDU_REM,   -64'sd5, 64'd0,   64'hFFFF_FFFF_FFFF_FFFB, "rem_m5_0");
        run_op(MDU_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, "div_min_m1");
        run_op(MDU_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, "rem_min_m1");
        run_op(MDU_MULW,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, "mulw_max_2");
        run_op(MDU_DIVUW, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, "divuw_ones_2");
        run_op(MDU_DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, "divw_min_m1");
        run_op(MDU_REMW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'd0, "remw_min_m1");
        run_op(MDU_DIVW,  64'd9, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "divw_9_0");
        run_op(mdufunc_t'(4'hF), 64'd6, 64'd7, 64'd42, "invalid_func_mul");

        // Flush while idle must block the accept.
        func     = MDU_DIVU;
        a        = 64'd9;
        b        = 64'd3;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check_output("idle_flush_in_ready", u64'(in_ready), 64'd1);

        // Back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        apply_stimulus(MDU_MUL, 64'd3, 64'd5, 1'b1, 64'd15, "mul_hold");
        wait_result("mul_hold");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_output("hold_c", c, 64'd15);
            check_output("hold_out_valid", u64'(out_valid), 64'd1);
            check_output("hold_in_ready", u64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("release_in_ready", u64'(in_ready), 64'd1);
        check_output("release_out_valid", u64'(out_valid), 64'd0);

        // Flush in the 20th busy cycle kills the op.
        apply_stimulus(MDU_DIV, 64'd100, 64'd7, 1'b0, 64'd0, "div_flushed");
        repeat (19) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_output("flush_in_ready", u64'(in_ready), 64'd1);
        check_output("flush_out_valid", u64'(out_valid), 64'd0);
        rises = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) rises++;
        end
        check_output("flush_no_output", u64'(rises), 64'd0);
        run_op(MDU_DIVU, 64'd9, 64'd3, 64'd3, "divu_after_flush");

        // Reset asserted mid-operation returns outputs to reset values at once.
        apply_stimulus(MDU_DIV, 64'd1000, 64'd3, 1'b0, 64'd0, "div_reset");
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("midreset_in_ready", u64'(in_ready), 64'd1);
        check_output("midreset_out_valid", u64'(out_valid), 64'd0);
        check_output("midreset_c", c, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op(MDU_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "remw_m7_2");
        run_op(MDU_DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "divw_m7_2");

        repeat (3) @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            check_output("scoreboard_drained", u64'(sb_q.size()), 64'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
